// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), with valid/ready on both sides.
module alu_multicycle #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] srca,
    input  logic [n-1:0] srcb,
    input  logic [3:0]   alucontrol,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] aluout,
    output logic [n-1:0] aluhi,
    output logic         zero,
    output logic         busy
);

    localparam int SW = $clog2(n);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(n);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_MULU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    function automatic logic [n-1:0] single_op(input logic [3:0] op,
                                               input logic [n-1:0] a,
                                               input logic [n-1:0] b);
        logic [SW-1:0] sh;
        logic [n-1:0]  r;
        sh = b[SW-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(n-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SRA:  r = $signed(a) >>> sh;
            default: r = {n{1'b0}};
        endcase
        return r;
    endfunction

    // One shift-add step: returns {acc, lo} shifted right with conditional add.
    function automatic logic [2*n-1:0] mul_step(input logic [n-1:0] acc,
                                                input logic [n-1:0] lo,
                                                input logic [n-1:0] a);
        logic [n:0] sum;
        if (lo[0]) begin
            sum = {1'b0, acc} + {1'b0, a};
        end else begin
            sum = {1'b0, acc};
        end
        return {sum, lo[n-1:1]};
    endfunction

    // One restoring step: acc is the partial remainder, lo shifts dividend out and quotient in.
    function automatic logic [2*n-1:0] div_step(input logic [n-1:0] acc,
                                                input logic [n-1:0] lo,
                                                input logic [n-1:0] d);
        logic [n:0] shifted;
        logic [n:0] diff;
        shifted = {acc, lo[n-1]};
        diff    = shifted - {1'b0, d};
        if (!diff[n]) begin
            return {diff[n-1:0], lo[n-2:0], 1'b1};
        end else begin
            return {shifted[n-1:0], lo[n-2:0], 1'b0};
        end
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [n-1:0]  a_q, a_d;
    logic [n-1:0]  acc_q, acc_d;
    logic [n-1:0]  lo_q, lo_d;
    logic [n-1:0]  aluout_q, aluout_d;
    logic [n-1:0]  aluhi_q, aluhi_d;
    logic          zero_q, zero_d;
    logic          out_valid_q, out_valid_d;
    logic [n-1:0]  res_s;
    logic [2*n-1:0] step_s;

    // Next-state, datapath iteration and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        aluout_d    = aluout_q;
        aluhi_d     = aluhi_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        res_s       = single_op(alucontrol, srca, srcb);
        if (op_q == OP_MULU) begin
            step_s = mul_step(acc_q, lo_q, a_q);
        end else begin
            step_s = div_step(acc_q, lo_q, a_q);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (alucontrol == OP_MULU || alucontrol == OP_DIVU) begin
                        state_d = S_CALC;
                        cnt_d   = CNT_LOAD;
                        op_d    = alucontrol;
                        acc_d   = {n{1'b0}};
                        if (alucontrol == OP_MULU) begin
                            a_d  = srca;
                            lo_d = srcb;
                        end else begin
                            a_d  = srcb;
                            lo_d = srca;
                        end
                    end else begin
                        state_d     = S_DONE;
                        aluout_d    = res_s;
                        aluhi_d     = {n{1'b0}};
                        zero_d      = (res_s == {n{1'b0}});
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = step_s[2*n-1:n];
                lo_d  = step_s[n-1:0];
                cnt_d = cnt_q - CNT_ONE;
                // Last iteration publishes the result on the same edge.
                if (cnt_q == CNT_ONE) begin
                    state_d     = S_DONE;
                    aluout_d    = step_s[n-1:0];
                    aluhi_d     = step_s[2*n-1:n];
                    zero_d      = (step_s[n-1:0] == {n{1'b0}});
                    out_valid_d = 1'b1;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            op_q        <= 4'b0000;
            a_q         <= {n{1'b0}};
            acc_q       <= {n{1'b0}};
            lo_q        <= {n{1'b0}};
            aluout_q    <= {n{1'b0}};
            aluhi_q     <= {n{1'b0}};
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            aluout_q    <= aluout_d;
            aluhi_q     <= aluhi_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign aluout    = aluout_q;
    assign aluhi     = aluhi_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, random ops
// against an arithmetic reference model, backpressure and mid-operation reset.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] srca = 32'h0;
    logic [31:0] srcb = 32'h0;
    logic [3:0]  alucontrol = 4'h0;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] aluout, aluhi;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    alu_multicycle #(.n(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .aluhi(aluhi), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: results straight from the opcode definitions using wide arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic z, output int lat);
        logic [63:0] p;
        int unsigned sh;
        sh  = b % 32;
        hi  = 32'h0;
        lat = 1;
        case (op)
            4'd0:  lo = a + b;
            4'd1:  lo = a - b;
            4'd2:  lo = a << sh;
            4'd3:  lo = a >> sh;
            4'd4:  lo = a & b;
            4'd5:  lo = a | b;
            4'd6:  lo = a ^ b;
            4'd7:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  lo = $signed(a) >>> sh;
            4'd9: begin
                p   = 64'(a) * 64'(b);
                lo  = p[31:0];
                hi  = p[63:32];
                lat = 33;
            end
            4'd10: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFFFFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
                lat = 33;
            end
            default: lo = 32'h0;
        endcase
        z = (lo == 32'h0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_z, input int exp_lat, input int hold);
        int k;
        int cyc;
        int bad;
        logic [31:0] prev_lo, prev_hi;
        logic prev_z;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_in_ready"}, in_ready, 1);
        prev_lo = aluout;
        prev_hi = aluhi;
        prev_z  = zero;
        in_valid   = 1'b1;
        srca       = a;
        srcb       = b;
        alucontrol = op;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        srca       = $urandom;
        srcb       = $urandom;
        alucontrol = 4'($urandom);
        cyc = 1;
        bad = 0;
        @(negedge clk);
        while (!out_valid && cyc < 200) begin
            if (!busy || in_ready || aluout !== prev_lo || aluhi !== prev_hi || zero !== prev_z)
                bad++;
            in_valid = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_calc_stable"}, bad, 0);
        check({name, "_out_valid"}, out_valid, 1);
        check({name, "_aluout"}, aluout, exp_lo);
        check({name, "_aluhi"}, aluhi, exp_hi);
        check({name, "_zero"}, zero, exp_z);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            if (!out_valid || in_ready || aluout !== exp_lo || aluhi !== exp_hi || zero !== exp_z)
                bad++;
        end
        in_valid = 1'b0;
        if (hold > 0) check({name, "_hold_stable"}, bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_back_idle"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] mlo, mhi;
        logic        mz;
        int          mlat;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1};
        vecs[1]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1};
        vecs[2]  = '{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1};
        vecs[3]  = '{4'h8, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0, 1};
        vecs[4]  = '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
        vecs[5]  = '{4'hA, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
        vecs[6]  = '{4'hA, 32'h00001234, 32'h0, 32'hFFFFFFFF, 32'h00001234, 1'b0, 33};
        vecs[7]  = '{4'hD, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 32'h0, 1'b1, 1};
        vecs[8]  = '{4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1};
        vecs[9]  = '{4'h5, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1};
        vecs[10] = '{4'h6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1};
        vecs[11] = '{4'h2, 32'h00000001, 32'h0000003F, 32'h80000000, 32'h0, 1'b0, 1};
        vecs[12] = '{4'h3, 32'h80000000, 32'h00000021, 32'h40000000, 32'h0, 1'b0, 1};
        vecs[13] = '{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1};
        vecs[14] = '{4'h8, 32'h40000000, 32'h00000004, 32'h04000000, 32'h0, 1'b0, 1};
        vecs[15] = '{4'h9, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 33};
        vecs[16] = '{4'hA, 32'd5, 32'd10, 32'd0, 32'd5, 1'b1, 33};
        vecs[17] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b1, 1};

        #2 reset = 1'b1;
        #1;
        check("reset_aluout", aluout, 0);
        check("reset_aluhi", aluhi, 0);
        check("reset_zero", zero, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].lo, vecs[i].hi, vecs[i].z, vecs[i].lat, 0);
        end

        run_op("backpressure_add", 4'h0, 32'd10, 32'd20, 32'd30, 32'h0, 1'b0, 1, 5);
        run_op("backpressure_mul", 4'h9, 32'd3, 32'd4, 32'd12, 32'h0, 1'b0, 33, 3);

        // Reset ten cycles into a multiply, then a clean add.
        @(negedge clk);
        in_valid   = 1'b1;
        srca       = 32'hFFFFFFFF;
        srcb       = 32'hFFFFFFFF;
        alucontrol = 4'h9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_aluout", aluout, 0);
        check("abort_aluhi", aluhi, 0);
        check("abort_zero", zero, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_abort_add", 4'h0, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1, 0);
        run_op("after_abort_mul", 4'h9, 32'd6, 32'd7, 32'd42, 32'h0, 1'b0, 33, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (i % 4 == 0) rop = 4'($urandom_range(9, 10));
            ra = $urandom;
            rb = (i % 7 == 3) ? 32'h0 : $urandom;
            if (i % 5 == 1) rb = rb >> $urandom_range(0, 31);
            model(rop, ra, rb, mlo, mhi, mz, mlat);
            run_op($sformatf("rand%0d_op%0h", i, rop), rop, ra, rb, mlo, mhi, mz, mlat, i % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
